// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray conversion and the full-compare pointer transform.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int PTR_MAX_W          = 16;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A full FIFO's write Gray pointer equals the read Gray pointer with its top two bits inverted.
  function automatic logic [PTR_MAX_W-1:0] full_cmp_ptr(input logic [PTR_MAX_W-1:0] g,
                                                       input int unsigned w);
    return g ^ (PTR_MAX_W'(2'b11) << (w - 2));
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/memory-side bus of the FIFO write arbiter; master = arbiter, slave = environment.
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [ADDR_WIDTH:0]           wq2_rptr;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         w_data;
  logic [ADDR_WIDTH-1:0]         w_addr;
  logic [ADDR_WIDTH:0]           wptr;
  logic                          wfull;

  modport master (
    input  req, req_data, wq2_rptr,
    output grant, winc, w_data, w_addr, wptr, wfull
  );

  modport slave (
    output req, req_data, wq2_rptr,
    input  grant, winc, w_data, w_addr, wptr, wfull
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin priority rotate: searches upward from last_grant+1, wrapping.
// Latency: combinational. Backpressure: caller masks req to suppress all grants.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (grant == '0 && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side FIFO controller: round-robin shares the memory write port, owns wptr and wfull.
// Latency: zero-cycle accept (grant is combinational); pointers and wfull registered.
// Backpressure: no grant while wfull or W_RST; requesters hold req/data until granted.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REQ    = 4
) (
  input logic                W_CLK,
  input logic                W_RST,
  fifo_wr_arbiter_if.master  bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [PW-1:0]         wbin;
  logic [PW-1:0]         wptr_q;
  logic                  wfull_q;
  logic [IDX_W-1:0]      last_grant;
  logic [NUM_REQ-1:0]    req_ok;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  winc;
  logic [PW-1:0]         wbin_next;
  logic [PW-1:0]         wgnext;
  logic [PW-1:0]         full_ptr;
  logic [DATA_WIDTH-1:0] w_data;

  assign req_ok = (W_RST || wfull_q) ? '0 : bus.req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_ok),
    .last_grant (last_grant),
    .grant      (gnt),
    .grant_idx  (gnt_idx)
  );

  assign winc = |gnt;

  // Unselected cycles present requester 0's slice.
  always_comb begin
    w_data = bus.req_data[DATA_WIDTH-1:0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wbin_next = wbin + PW'(winc);
  assign wgnext    = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
  assign full_ptr  = PW'(full_cmp_ptr(PTR_MAX_W'(bus.wq2_rptr), PW));

  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      wbin       <= '0;
      wptr_q     <= '0;
      wfull_q    <= 1'b0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      wbin    <= wbin_next;
      wptr_q  <= wgnext;
      wfull_q <= (wgnext == full_ptr);
      if (winc) begin
        last_grant <= gnt_idx;
      end
    end
  end

  assign bus.grant  = gnt;
  assign bus.winc   = winc;
  assign bus.w_data = w_data;
  assign bus.w_addr = wbin[ADDR_WIDTH-1:0];
  assign bus.wptr   = wptr_q;
  assign bus.wfull  = wfull_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: each driven cycle pushes its expected outputs, checked at negedge.
module tb_fifo_wr_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic       winc;
    logic [7:0] data;
    logic [2:0] addr;
    logic [3:0] wptr;
    logic       wfull;
  } exp_t;

  logic clk;
  logic rst;
  fifo_wr_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REQ(4)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REQ(4)) dut (
    .W_CLK (clk),
    .W_RST (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  exp_t       sb[$];
  logic [7:0] dat[4];
  int         n_chk;
  int         n_fail;

  logic [3:0] m_wbin;
  logic       m_full;
  int         m_last;

  logic [3:0] s_grant;
  logic       s_winc;
  logic [7:0] s_data;
  logic [2:0] s_addr;
  logic [3:0] s_wptr;
  logic       s_wfull;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, queue its expectation, compare at negedge, then advance the model past the edge.
  task automatic step(input logic r_rst, input logic [3:0] r_req, input logic [3:0] r_rptr);
    exp_t       e;
    exp_t       o;
    int         gi;
    logic [3:0] nb;
    rst          = r_rst;
    bus.req      = r_req;
    bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
    bus.wq2_rptr = r_rptr;
    e.grant = '0;
    gi      = 0;
    if (!r_rst && !m_full) begin
      for (int off = 1; off <= 4; off++) begin
        int idx;
        idx = (m_last + off) % 4;
        if (e.grant == 4'b0 && r_req[idx]) begin
          e.grant[idx] = 1'b1;
          gi = idx;
        end
      end
    end
    e.winc  = |e.grant;
    e.data  = dat[gi];
    e.addr  = m_wbin[2:0];
    e.wptr  = gray4(m_wbin);
    e.wfull = m_full;
    sb.push_back(e);

    @(negedge clk);
    s_grant = bus.grant;
    s_winc  = bus.winc;
    s_data  = bus.w_data;
    s_addr  = bus.w_addr;
    s_wptr  = bus.wptr;
    s_wfull = bus.wfull;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: no expectation queued at %0t", $time);
    end else begin
      o = sb.pop_front();
      chk("grant", 32'(s_grant), 32'(o.grant));
      chk("winc", 32'(s_winc), 32'(o.winc));
      if (o.winc) chk("w_data", 32'(s_data), 32'(o.data));
      chk("w_addr", 32'(s_addr), 32'(o.addr));
      chk("wptr", 32'(s_wptr), 32'(o.wptr));
      chk("wfull", 32'(s_wfull), 32'(o.wfull));
    end

    @(posedge clk);
    if (r_rst) begin
      m_wbin = '0;
      m_full = 1'b0;
      m_last = 3;
    end else begin
      nb     = m_wbin + {3'b0, e.winc};
      m_full = (gray4(nb) == {~r_rptr[3:2], r_rptr[1:0]});
      if (e.winc) m_last = gi;
      m_wbin = nb;
    end
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom_range(0, 255));
  endtask

  logic [3:0] rot_exp[5];
  logic [3:0] skip_exp[4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_wbin = '0;
    m_full = 1'b0;
    m_last = 3;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.wq2_rptr = '0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    rot_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    skip_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    // Reset held two edges with all requesters active.
    step(1'b1, 4'b1111, 4'b0000);
    chk("rst_grant", 32'(s_grant), 32'h0);
    step(1'b1, 4'b1111, 4'b0000);
    chk("rst_wptr", 32'(s_wptr), 32'h0);
    randomize_data();
    step(1'b0, 4'b1111, 4'b0000);
    chk("first_grant", 32'(s_grant), 32'b0001);

    // Fill: single requester, read pointer parked at 0.
    step(1'b1, 4'b0000, 4'b0000);
    for (int n = 0; n < 8; n++) begin
      dat[0] = 8'hA0 + 8'(n);
      step(1'b0, 4'b0001, 4'b0000);
      chk("fill_addr", 32'(s_addr), 32'(n));
      chk("fill_data", 32'(s_data), 32'(8'hA0 + 8'(n)));
    end
    step(1'b0, 4'b0001, 4'b0000);
    chk("full_flag", 32'(s_wfull), 32'h1);
    chk("full_wptr", 32'(s_wptr), 32'b1100);
    chk("full_grant", 32'(s_grant), 32'h0);

    // Full release: read side consumed one word.
    step(1'b0, 4'b0001, 4'b0001);
    dat[0] = 8'h5A;
    step(1'b0, 4'b0001, 4'b0001);
    chk("rel_wfull", 32'(s_wfull), 32'h0);
    chk("rel_addr", 32'(s_addr), 32'h0);
    chk("rel_winc", 32'(s_winc), 32'h1);
    step(1'b0, 4'b0001, 4'b0001);
    chk("refull_wptr", 32'(s_wptr), 32'b1101);
    chk("refull_flag", 32'(s_wfull), 32'h1);

    // Rotation with the read pointer tracking the write pointer.
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      randomize_data();
      step(1'b0, 4'b1111, gray4(m_wbin));
      chk("rot_grant", 32'(s_grant), 32'(rot_exp[k]));
    end

    // Skip: requesters 1 and 3 idle.
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      randomize_data();
      step(1'b0, 4'b0101, gray4(m_wbin));
      chk("skip_grant", 32'(s_grant), 32'(skip_exp[k]));
    end
    step(1'b0, 4'b0000, gray4(m_wbin));
    chk("idle_winc", 32'(s_winc), 32'h0);

    // Mid-operation reset after five writes.
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      randomize_data();
      step(1'b0, 4'b1111, 4'b0000);
    end
    step(1'b1, 4'b1111, 4'b0000);
    chk("midrst_grant", 32'(s_grant), 32'h0);
    randomize_data();
    step(1'b0, 4'b1111, 4'b0000);
    chk("midrst_wptr", 32'(s_wptr), 32'h0);
    chk("midrst_wfull", 32'(s_wfull), 32'h0);
    chk("midrst_grant0", 32'(s_grant), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the FIFO memory block. It shares the single write port among NUM_REQ requesters using round-robin arbitration.
- Drives the memory's winc/w_data/w_addr and owns the write pointer (binary and Gray) and the registered wfull flag.
- Takes the read pointer, already synchronised into the W_CLK domain as Gray code, and returns its own Gray pointer for the read-side synchroniser.

Parameters:
- DATA_WIDTH, 8, word width; matches the memory.
- ADDR_WIDTH, 3, memory address width; FIFO depth = 2**ADDR_WIDTH; minimum 2.
- NUM_REQ, 4, number of requesters; 2..8.

Ports:
- W_CLK  in  1  write-domain clock.
- W_RST  in  1  reset; one clock; reset is synchronous and active-high.
- req  in  NUM_REQ  per-requester write request; held with data until granted.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  out  NUM_REQ  one-hot, combinational; word accepted at this W_CLK edge.
- wq2_rptr  in  ADDR_WIDTH+1  synchronised read pointer, Gray code.
- winc  out  1  write enable to memory.
- w_data  out  DATA_WIDTH  selected word to memory.
- w_addr  out  ADDR_WIDTH  write address (binary pointer LSBs).
- wptr  out  ADDR_WIDTH+1  write pointer, Gray code, registered.
- wfull  out  1  FIFO full, registered.

Behaviour:
- State: wbin[ADDR_WIDTH:0], wptr (Gray), wfull, and last_grant index (clog2(NUM_REQ) bits).
- Reset, while W_RST is high at a W_CLK edge:
  - wbin=0, wptr=0, wfull=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
  - grant and winc are forced to 0 combinationally while W_RST is high.
- Arbitration, combinational each cycle:
  - If wfull=1 or req=0: grant=0, winc=0.
  - Otherwise grant the first requester with req set, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - Exactly one grant bit is high; winc=|grant.
  - w_data = req_data slice of the granted index; when winc=0, w_data is the slice of index 0 (don't-care).
- Handshake:
  - The word transfers at the W_CLK edge where grant[i]=1. Zero-latency accept; no grant pulse is delayed or registered.
  - The requester may present its next word in the following cycle, or drop req.
  - req may drop without a grant; no word is written in that case.
- On an edge with winc=1:
  - last_grant <= granted index.
  - wbin <= wbin+1, wrapping at 2**(ADDR_WIDTH+1).
  - wptr <= (wbin+1) ^ ((wbin+1)>>1).
- On an edge with winc=0: last_grant, wbin and wptr hold.
- w_addr = wbin[ADDR_WIDTH-1:0]; the memory writes this address on the same edge.
- Full flag:
  - wgnext = Gray(wbin + winc).
  - Every non-reset edge: wfull <= (wgnext == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
  - wfull rises on the edge of the write that fills the last slot, so it is never asserted late.
  - wfull falls one edge after wq2_rptr advances.
- Boundaries:
  - The write that fills the last slot is granted normally, and wfull=1 from the next cycle.
  - A write is never issued while wfull=1, so the memory's winc && !wfull gating is redundant but consistent.
  - Pointer wrap is ordinary modular increment; the extra MSB distinguishes full from empty.
  - A read-pointer advance in the same cycle as a write uses the new wq2_rptr in the wfull compare.
  - A single active requester is granted every cycle.
  - Reset mid-burst discards pointer state immediately. The memory contents are not the arbiter's concern.

Decomposition:
- Shared package fifo_pkg: bin2gray function, default DATA_WIDTH/ADDR_WIDTH, and full-compare helper (invert top two Gray bits).
- One sub-module, rr_arbiter: req, last_grant -> one-hot grant and index; purely combinational priority rotate.
- Pointer, flag and last_grant registers stay in fifo_wr_arbiter.

Test Plan:
- Reset: W_RST=1 for 2 edges with req=4'b1111 -> grant=0, winc=0, wptr=0, wfull=0; after release, first grant=4'b0001.
- Fill: req=4'b0001, data 0xA0+n, wq2_rptr=0 held.
  - 8 consecutive grants with w_addr 0..7.
  - After the 8th edge: wfull=1, wptr=4'b1100, grant=0, winc=0.
- Rotation: req=4'b1111, wq2_rptr tracking so never full -> grant sequence 0001,0010,0100,1000,0001; w_data follows each slice.
- Skip: req=4'b0101 -> grants 0001,0100,0001,0100; requesters 1 and 3 are never granted.
- Full release: from full (wptr=1100), drive wq2_rptr=4'b0001.
  - Next edge: wfull=0.
  - One write to w_addr 0 follows, then wptr=1101 and wfull=1 again.
- Mid-operation reset: W_RST=1 after 5 writes with req held -> same edge: wptr=0, wfull=0, grant=0; after release, the requester after index 3 (index 0) is granted.
